// File: rtl/fft_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : fft_reorder
//  Description : Bit-reversal reorder buffer for a 32-point pipelined FFT.
//                It receives samples in bit-reversed bin order and re-emits
//                each frame in natural bin order (0..N-1), marking bin 0 with
//                sop_o and bin N-1 with eop_o. A two-bank ping-pong memory
//                lets one frame be written while the previous one is read,
//                so one sample per cycle is sustained without stalls.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                valid_i           - input sample strobe (FFT finish)
//                data_in_r/_i      - input sample, real/imag, signed DW bits
//                valid_o           - output sample valid
//                sop_o / eop_o     - first / last bin of a frame
//                index_o           - natural bin index of the output sample
//                data_out_r/_i     - output sample, real/imag, bit-exact
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_reorder #(
    parameter int DW    = 18,
    parameter int LOG2N = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic signed [DW-1:0]    data_in_r,
    input  logic signed [DW-1:0]    data_in_i,
    output logic                    valid_o,
    output logic                    sop_o,
    output logic                    eop_o,
    output logic [LOG2N-1:0]        index_o,
    output logic signed [DW-1:0]    data_out_r,
    output logic signed [DW-1:0]    data_out_i
);

    localparam int               N    = 1 << LOG2N;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    // Bank select is the MSB of the memory address.
    logic [2*DW-1:0]      mem_q [2*N];

    state_t               state_q,   state_d;
    logic [1:0]           full_q,    full_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0]     wr_cnt_q,  wr_cnt_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0]     rd_addr_q, rd_addr_d;
    logic                 valid_q,   valid_d;
    logic                 sop_q,     sop_d;
    logic                 eop_q,     eop_d;
    logic [LOG2N-1:0]     index_q,   index_d;
    logic signed [DW-1:0] dr_q,      dr_d;
    logic signed [DW-1:0] di_q,      di_d;

    logic [1:0]           w_set;
    logic [1:0]           w_clr;
    logic                 w_rd_go;
    logic [2*DW-1:0]      w_rd_word;

    assign w_rd_word = mem_q[{rd_bank_q, rd_addr_q}];

    // Sample storage is not reset; the full flags guard every read.
    always_ff @(posedge clk) begin
        if (valid_i && !rst) begin
            mem_q[{wr_bank_q, bitrev(wr_cnt_q)}] <= {data_in_r, data_in_i};
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        valid_d   = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        index_d   = index_q;
        dr_d      = dr_q;
        di_d      = di_q;
        w_set     = 2'b00;
        w_clr     = 2'b00;
        w_rd_go   = 1'b0;

        // Writer: store arrivals at their bit-reversed (natural) address.
        if (valid_i) begin
            wr_cnt_d = wr_cnt_q + ONE;
            if (wr_cnt_q == LAST) begin
                w_set[wr_bank_q] = 1'b1;
                wr_bank_d        = ~wr_bank_q;
            end
        end

        // Reader: IDLE launches address 0 on the same edge it sees a full
        // bank, so a frame that completes while the previous one drains
        // follows it with no bubble. rd_addr is always 0 in IDLE.
        case (state_q)
            S_IDLE:  w_rd_go = full_q[rd_bank_q];
            S_READ:  w_rd_go = 1'b1;
            default: w_rd_go = 1'b0;
        endcase

        if (w_rd_go) begin
            valid_d   = 1'b1;
            index_d   = rd_addr_q;
            sop_d     = (rd_addr_q == '0);
            eop_d     = (rd_addr_q == LAST);
            dr_d      = w_rd_word[2*DW-1:DW];
            di_d      = w_rd_word[DW-1:0];
            rd_addr_d = rd_addr_q + ONE;
            state_d   = S_READ;
            if (rd_addr_q == LAST) begin
                w_clr[rd_bank_q] = 1'b1;
                rd_bank_d        = ~rd_bank_q;
                state_d          = S_IDLE;
            end
        end

        // A set from the writer takes priority over a clear from the reader.
        full_d = (full_q & ~w_clr) | w_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            index_q   <= '0;
            dr_q      <= '0;
            di_q      <= '0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            index_q   <= index_d;
            dr_q      <= dr_d;
            di_q      <= di_d;
        end
    end

    assign valid_o    = valid_q;
    assign sop_o      = sop_q;
    assign eop_o      = eop_q;
    assign index_o    = index_q;
    assign data_out_r = dr_q;
    assign data_out_i = di_q;

endmodule
`default_nettype wire
